scan_sequencer_8_32: RTL and testbench

- Upstream source stage for top_selector_8_32.
- Holds an 8-entry x 32-bit word bank that drives the selector's x inputs directly.
- Sequences the selector's s input over the written entries only, in ascending index order.
- A valid/ready handshake paces each scan step, so the consumer of y_selector_8_32 sees exactly one word per accepted beat.

---
 rtl/sel_pkg.sv | 15 +
 rtl/priority_next_8.sv | 24 ++
 rtl/scan_sequencer_8_32.sv | 125 ++++++++++++
 tb/tb_scan_sequencer_8_32.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared types and sizes for the scan sequencer feeding top_selector_8_32.
// Holds word width, bank depth, select width and the sequencer state type.
package sel_pkg;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int SEL_W = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/priority_next_8.sv
// Finds the lowest set mask bit above cur (or at/above cur when incl is set).
// Ports: mask, cur, incl in; nxt index and found flag out.
module priority_next_8
    import sel_pkg::*;
(
    input  logic [DEPTH-1:0] mask,
    input  logic [SEL_W-1:0] cur,
    input  logic             incl,
    output logic [SEL_W-1:0] nxt,
    output logic             found
);
    // Walk downward so the lowest qualifying index is the last one written.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (mask[i] &&
                ((SEL_W'(i) > cur) || (incl && (SEL_W'(i) == cur)))) begin
                nxt   = SEL_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/scan_sequencer_8_32.sv
// Word bank plus select sequencer that steps s over written entries in order.
// Ports: clk/rst_n, bank write (wr_en/wr_addr/wr_data), clear_i, start_i,
// ready_i in; x bank, s, valid_o, last_o, busy_o, done_o, wr_drop_o out.
module scan_sequencer_8_32
    import sel_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     x [DEPTH],
    output logic [SEL_W-1:0]     s,
    output logic                 valid_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 wr_drop_o
);
    state_t           state, state_d;
    logic [DEPTH-1:0] vmask, vmask_d;
    logic [SEL_W-1:0] s_d;
    logic             wr_commit;
    logic             drop_d;

    logic [DEPTH-1:0] wr_onehot;
    logic [DEPTH-1:0] idle_mask;
    logic [SEL_W-1:0] first_idx, next_idx;
    logic             first_found, next_found;

    // Mask as it will stand after this cycle's clear and write in IDLE,
    // so a write issued with start_i joins the scan.
    assign wr_onehot = DEPTH'(1) << wr_addr;
    assign idle_mask = (clear_i ? '0 : vmask) | (wr_en ? wr_onehot : '0);

    priority_next_8 u_first (
        .mask  (idle_mask),
        .cur   ('0),
        .incl  (1'b1),
        .nxt   (first_idx),
        .found (first_found)
    );

    priority_next_8 u_next (
        .mask  (vmask),
        .cur   (s),
        .incl  (1'b0),
        .nxt   (next_idx),
        .found (next_found)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vmask     <= '0;
            s         <= '0;
            wr_drop_o <= 1'b0;
        end else begin
            state     <= state_d;
            vmask     <= vmask_d;
            s         <= s_d;
            wr_drop_o <= drop_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                x[i] <= '0;
            end
        end else if (wr_commit) begin
            x[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state;
        vmask_d   = vmask;
        s_d       = s;
        wr_commit = 1'b0;
        drop_d    = 1'b0;
        unique case (state)
            IDLE: begin
                vmask_d   = idle_mask;
                wr_commit = wr_en;
                if (start_i) begin
                    if (first_found) begin
                        state_d = SCAN;
                        s_d     = first_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            SCAN: begin
                drop_d = wr_en;
                if (ready_i) begin
                    if (next_found) begin
                        s_d = next_idx;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                wr_commit = wr_en;
                if (wr_en) begin
                    vmask_d = vmask | wr_onehot;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign valid_o = (state == SCAN);
    assign busy_o  = (state == SCAN);
    assign last_o  = (state == SCAN) && !next_found;
    assign done_o  = (state == DONE);
endmodule

// File: tb/tb_scan_sequencer_8_32.sv
// Directed bench for scan_sequencer_8_32 with hand-computed expectations.
// Drives inputs just after the rising edge and checks registered outputs.
module tb_scan_sequencer_8_32;
    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clear_i;
    logic        start_i;
    logic        ready_i;
    logic [31:0] x [8];
    logic [2:0]  s;
    logic        valid_o;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic        wr_drop_o;

    int n_chk;
    int n_err;

    scan_sequencer_8_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clear_i   (clear_i),
        .start_i   (start_i),
        .ready_i   (ready_i),
        .x         (x),
        .s         (s),
        .valid_o   (valid_o),
        .last_o    (last_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .wr_drop_o (wr_drop_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic fill_bank();
        for (int i = 0; i < 8; i++) begin
            wr(3'(i), 32'h1 << (4 * i));
        end
    endtask

    task automatic go();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    logic [2:0]  exp_s [3];
    logic [31:0] exp_y [3];
    bit          seen;

    initial begin
        n_chk   = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clear_i = 1'b0;
        start_i = 1'b0;
        ready_i = 1'b0;

        // Reset holds everything at zero
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rst_x%0d", i), x[i], 32'h0);
        end
        check("rst_s", 32'(s), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_last", 32'(last_o), 32'd0);
        check("rst_drop", 32'(wr_drop_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full bank scan at full rate
        fill_bank();
        ready_i = 1'b1;
        go();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("full_s%0d", k), 32'(s), 32'(k));
            check($sformatf("full_v%0d", k), 32'(valid_o), 32'd1);
            check($sformatf("full_y%0d", k), x[s], 32'h1 << (4 * k));
            check($sformatf("full_l%0d", k), 32'(last_o), 32'(k == 7));
            tick();
        end
        check("full_done", 32'(done_o), 32'd1);
        check("full_done_v", 32'(valid_o), 32'd0);
        tick();
        check("full_idle_done", 32'(done_o), 32'd0);
        check("full_idle_busy", 32'(busy_o), 32'd0);

        // Backpressure at s = 2
        go();
        tick();
        tick();
        check("bp_s2", 32'(s), 32'd2);
        ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_hold_s%0d", k), 32'(s), 32'd2);
            check($sformatf("bp_hold_v%0d", k), 32'(valid_o), 32'd1);
            check($sformatf("bp_hold_y%0d", k), x[s], 32'h00000100);
        end
        ready_i = 1'b1;
        tick();
        check("bp_resume", 32'(s), 32'd3);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            seen = done_o;
        end
        check("bp_done_seen", 32'(seen), 32'd1);
        tick();

        // Sparse scan over entries 1, 4, 6
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        wr(3'd1, 32'hA1);
        wr(3'd4, 32'hA4);
        wr(3'd6, 32'hA6);
        exp_s = '{3'd1, 3'd4, 3'd6};
        exp_y = '{32'hA1, 32'hA4, 32'hA6};
        go();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sp_s%0d", k), 32'(s), 32'(exp_s[k]));
            check($sformatf("sp_y%0d", k), x[s], exp_y[k]);
            check($sformatf("sp_l%0d", k), 32'(last_o), 32'(k == 2));
            tick();
        end
        check("sp_done", 32'(done_o), 32'd1);
        tick();

        // Empty mask: straight to DONE
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("empty_v_pre", 32'(valid_o), 32'd0);
        go();
        check("empty_done", 32'(done_o), 32'd1);
        check("empty_v", 32'(valid_o), 32'd0);
        tick();
        check("empty_done_off", 32'(done_o), 32'd0);
        check("empty_v_post", 32'(valid_o), 32'd0);

        // Dropped write during SCAN, then reset mid-scan
        fill_bank();
        ready_i = 1'b0;
        go();
        check("drop_busy", 32'(busy_o), 32'd1);
        wr(3'd5, 32'hDEAD);
        check("drop_pulse", 32'(wr_drop_o), 32'd1);
        check("drop_x5", x[5], 32'h00100000);
        tick();
        check("drop_off", 32'(wr_drop_o), 32'd0);
        check("drop_hold_s", 32'(s), 32'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_v", 32'(valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_x5", x[5], 32'h0);
        check("mid_rst_done", 32'(done_o), 32'd0);
        tick();
        check("mid_rst_done2", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_done", 32'(done_o), 32'd0);
        check("post_rst_v", 32'(valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
